// File: rtl/regfile_sb.sv
// Dual-write, dual-read register file for the dual-issue datapath, with an
// optional same-cycle write bypass and a per-register pending-write scoreboard.
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int BYPASS = 1,
   localparam int ABITS = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we3,
   input  logic [ABITS-1:0] wa3,
   input  logic [XLEN-1:0]  wd3,
   input  logic             we4,
   input  logic [ABITS-1:0] wa4,
   input  logic [XLEN-1:0]  wd4,
   input  logic [ABITS-1:0] ra1,
   input  logic [ABITS-1:0] ra2,
   output logic [XLEN-1:0]  rd1,
   output logic [XLEN-1:0]  rd2,
   input  logic             iss_en,
   input  logic [ABITS-1:0] iss_rd,
   output logic             busy1,
   output logic             busy2
);

   localparam bit BYP = (BYPASS != 0);

   logic [XLEN-1:0]  rf [NREGS];
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_nxt;

   logic wr3_ok, wr4_ok;
   logic hit3_1, hit4_1, hit3_2, hit4_2;

   // Address 0 is hardwired: writes, issues and bypass hits to it are dropped.
   assign wr3_ok = we3 && (wa3 != '0);
   assign wr4_ok = we4 && (wa4 != '0);

   always_comb begin
      pending_nxt = pending;
      if (wr3_ok) pending_nxt[wa3] = 1'b0;
      if (wr4_ok) pending_nxt[wa4] = 1'b0;
      // The newly issued producer is still outstanding, so set beats clear.
      if (iss_en && (iss_rd != '0)) pending_nxt[iss_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
         pending <= '0;
      end else begin
         if (wr3_ok) rf[wa3] <= wd3;
         // Port 4 is assigned last so it wins an address conflict.
         if (wr4_ok) rf[wa4] <= wd4;
         pending <= pending_nxt;
      end
   end

   always_comb begin
      hit3_1 = BYP && wr3_ok && (wa3 == ra1);
      hit4_1 = BYP && wr4_ok && (wa4 == ra1);
      hit3_2 = BYP && wr3_ok && (wa3 == ra2);
      hit4_2 = BYP && wr4_ok && (wa4 == ra2);
   end

   always_comb begin
      rd1 = rf[ra1];
      if (ra1 == '0)  rd1 = '0;
      else if (hit4_1) rd1 = wd4;
      else if (hit3_1) rd1 = wd3;

      rd2 = rf[ra2];
      if (ra2 == '0)  rd2 = '0;
      else if (hit4_2) rd2 = wd4;
      else if (hit3_2) rd2 = wd3;
   end

   // A bypassed write already delivers the data, so the hazard is resolved.
   always_comb begin
      busy1 = pending[ra1] && (ra1 != '0) && !(hit3_1 || hit4_1);
      busy2 = pending[ra2] && (ra2 != '0) && !(hit3_2 || hit4_2);
   end

endmodule
